// File: rtl/dmux_stream_scheduler_pkg.sv
// Shared definitions for the demux stream scheduler.
//   sched_state_t : scheduler FSM encoding (IDLE=0, STREAM=1, DRAIN=2)
package dmux_stream_scheduler_pkg;

  // IDLE   : demux pipeline empty, destination may be switched
  // STREAM : a beat was accepted in the previous cycle
  // DRAIN  : no accept, older beats still inside the demux pipeline
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/dmux_stream_scheduler_valid_delay.sv
// LATENCY-deep 1-bit shift register carrying "beat accepted" flags alongside
// the demux data pipeline. LATENCY=0 is a pass-through.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   accept   : a real beat entered the demux this cycle
//   strobe   : accept flag delayed by LATENCY cycles
//   pending  : any flag still in flight
module dmux_stream_scheduler_valid_delay #(
  parameter int LATENCY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  output logic strobe,
  output logic pending
);

  // Keep at least one storage bit so LATENCY=0 still elaborates cleanly; the
  // bit is unused in that build and is removed by synthesis.
  localparam int DEPTH = (LATENCY < 1) ? 1 : LATENCY;

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(accept);
    end
  end

  assign strobe  = (LATENCY == 0) ? accept : sr[DEPTH-1];
  assign pending = (LATENCY != 0) && (sr != '0);

endmodule

// File: rtl/dmux_stream_scheduler.sv
// Feeds a fixed-latency pipelined demultiplexer from a valid/ready stream
// while keeping the (unpipelined) demux select stable for every beat in
// flight. Same-destination beats stream back-to-back; a destination change
// waits for the pipeline to drain, then spends one cycle switching dm_sel.
//
// Handshake: a beat transfers in a cycle where s_valid && s_ready. s_ready is
// combinational on s_dest (not on s_valid) and is low during reset.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   s_valid   : upstream beat valid
//   s_ready   : upstream beat accepted when s_valid && s_ready
//   s_dest    : destination output index of the beat
//   s_data    : beat payload
//   dm_sel    : demux select
//   dm_in     : demux data input (zero when no beat is delivered)
//   m_valid   : one-hot qualifier for demux output slices
//   busy      : an accepted beat is still inside the demux pipeline
//   fsm_state : scheduler state, for observation
module dmux_stream_scheduler
  import dmux_stream_scheduler_pkg::*;
#(
  parameter  int WIDTH        = 1,
  parameter  int OUTPUT_COUNT = 2,
  parameter  int LATENCY      = 0,
  localparam int SEL_W        = $clog2(OUTPUT_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SEL_W-1:0]        s_dest,
  input  logic [WIDTH-1:0]        s_data,
  output logic [SEL_W-1:0]        dm_sel,
  output logic [WIDTH-1:0]        dm_in,
  output logic [OUTPUT_COUNT-1:0] m_valid,
  output logic                    busy,
  output sched_state_t            fsm_state
);

  localparam int               AGE_W     = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [AGE_W-1:0] AGE_EMPTY = AGE_W'(LATENCY);

  function automatic logic [OUTPUT_COUNT-1:0] onehot(input logic [SEL_W-1:0] idx);
    return OUTPUT_COUNT'(1) << idx;
  endfunction

  sched_state_t     state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [SEL_W-1:0] cur_sel, sel_d;
  logic             in_range;
  logic             accept;
  logic             deliver;
  logic             switch_sel;
  logic             strobe;
  logic             pending;

  // Out-of-range destinations only exist for non-power-of-two output counts.
  if ((1 << SEL_W) == OUTPUT_COUNT) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_npow2
    assign in_range = (int'(s_dest) < OUTPUT_COUNT);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      age_q   <= AGE_EMPTY;
      cur_sel <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      cur_sel <= sel_d;
    end
  end

  // Next-state logic. age counts cycles since the last accept and saturates
  // at LATENCY, which is exactly when the demux pipeline holds no beat.
  always_comb begin
    age_d   = age_q;
    state_d = state_q;
    sel_d   = cur_sel;
    if (accept) begin
      age_d = '0;
    end else if (age_q != AGE_EMPTY) begin
      age_d = age_q + AGE_W'(1);
    end
    if (accept) begin
      state_d = STREAM;
    end else if (age_d == AGE_EMPTY) begin
      state_d = IDLE;
    end else begin
      state_d = DRAIN;
    end
    // With a zero-latency demux the select is used combinationally, so it
    // just follows each delivered beat.
    if (switch_sel || (LATENCY == 0 && deliver)) begin
      sel_d = s_dest;
    end
  end

  // Output logic. A mismatching beat is only ever switched to from IDLE; the
  // switch cycle itself accepts nothing so dm_sel is settled before the beat.
  // Out-of-range beats count as a match: taken and dropped.
  always_comb begin
    s_ready    = 1'b0;
    switch_sel = 1'b0;
    if (!rst) begin
      if (LATENCY == 0 || !in_range || s_dest == cur_sel) begin
        s_ready = 1'b1;
      end else if (state_q == IDLE && s_valid) begin
        switch_sel = 1'b1;
      end
    end
    accept  = s_valid && s_ready;
    deliver = accept && in_range;
    dm_in   = deliver ? s_data : '0;
    if (rst) begin
      dm_sel = '0;
    end else if (LATENCY == 0 && deliver) begin
      dm_sel = s_dest;
    end else begin
      dm_sel = cur_sel;
    end
    m_valid   = (strobe && !rst) ? onehot(dm_sel) : '0;
    busy      = pending && !rst;
    fsm_state = state_q;
  end

  dmux_stream_scheduler_valid_delay #(
    .LATENCY (LATENCY)
  ) u_valid_delay (
    .clk     (clk),
    .rst     (rst),
    .accept  (deliver),
    .strobe  (strobe),
    .pending (pending)
  );

endmodule

// File: tb/tb_dmux_stream_scheduler.sv
module tb_dmux_stream_scheduler;
  import dmux_stream_scheduler_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  // ---------------- main DUT: WIDTH=8, OUTPUT_COUNT=4, LATENCY=2 ----------------
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [1:0] s_dest  = '0;
  logic [7:0] s_data  = '0;
  logic [1:0] dm_sel;
  logic [7:0] dm_in;
  logic [3:0] m_valid;
  logic       busy;
  sched_state_t fsm_state;

  dmux_stream_scheduler #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_dest(s_dest),
    .s_data(s_data), .dm_sel(dm_sel), .dm_in(dm_in), .m_valid(m_valid),
    .busy(busy), .fsm_state(fsm_state)
  );

  // Demux stand-in: two data register stages, select applied at the output.
  logic [7:0] p1, p2;
  logic [7:0] dm_out [4];
  always_ff @(posedge clk) begin
    p1 <= dm_in;
    p2 <= p1;
  end
  always_comb begin
    for (int d = 0; d < 4; d++) dm_out[d] = (dm_sel == 2'(d)) ? p2 : 8'h00;
  end

  // ---------------- OUTPUT_COUNT=3 build ----------------
  logic       v3 = 1'b0;
  logic       r3;
  logic [1:0] d3 = '0;
  logic [7:0] x3 = '0;
  logic [1:0] sel3;
  logic [7:0] in3;
  logic [2:0] mv3;
  logic       busy3;
  sched_state_t st3;

  dmux_stream_scheduler #(.WIDTH(8), .OUTPUT_COUNT(3), .LATENCY(2)) u_dut3 (
    .clk(clk), .rst(rst), .s_valid(v3), .s_ready(r3), .s_dest(d3),
    .s_data(x3), .dm_sel(sel3), .dm_in(in3), .m_valid(mv3),
    .busy(busy3), .fsm_state(st3)
  );

  // ---------------- LATENCY=0 build ----------------
  logic       v0 = 1'b0;
  logic       r0;
  logic [1:0] d0 = '0;
  logic [7:0] x0 = '0;
  logic [1:0] sel0;
  logic [7:0] in0;
  logic [3:0] mv0;
  logic       busy0;
  sched_state_t st0;

  dmux_stream_scheduler #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_valid(v0), .s_ready(r0), .s_dest(d0),
    .s_data(x0), .dm_sel(sel0), .dm_in(in0), .m_valid(mv0),
    .busy(busy0), .fsm_state(st0)
  );

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];   // {dest, data}
  int         due_q[$];   // cycle in which m_valid is due

  always @(negedge clk) begin
    if (!rst && m_valid != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("spurious_m_valid", 32'(m_valid), 32'(0));
      end else begin
        logic [9:0] e;
        int         due;
        e   = exp_q.pop_front();
        due = due_q.pop_front();
        check("m_valid", 32'(m_valid), 32'(4'b0001 << e[9:8]));
        check("out_data", 32'(dm_out[e[9:8]]), 32'(e[7:0]));
        check("latency", 32'(cycle), 32'(due));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until accepted; leaves s_valid high so
  // consecutive calls stream back-to-back. Returns the number of stall cycles.
  task automatic send(input logic [1:0] dest, input logic [7:0] data, output int stalls);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_dest  = dest;
    s_data  = data;
    @(negedge clk);
    while (!s_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      check("accept_timeout", 32'(0), 32'(1));
    end else begin
      check("dm_in_accept", 32'(dm_in), 32'(data));
      check("dm_sel_accept", 32'(dm_sel), 32'(dest));
      exp_q.push_back({dest, data});
      due_q.push_back(cycle + 2);
    end
    stalls = n;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st;
    logic [7:0] b3_data [4];

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;

    // Reset, with s_valid asserted: reset wins.
    s_valid = 1'b1;
    s_dest  = 2'd1;
    s_data  = 8'hAA;
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'(0));
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_dm_sel", 32'(dm_sel), 32'(0));
    check("rst_dm_in", 32'(dm_in), 32'(0));
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst = 1'b0;
    check("post_rst_state", 32'(fsm_state), 32'(IDLE));

    // 1. Same-destination stream (first beat pays the switch from dest 0).
    send(2'd2, 8'h11, st); check("t1_stall0", 32'(st), 32'(1));
    send(2'd2, 8'h22, st); check("t1_stall1", 32'(st), 32'(0));
    send(2'd2, 8'h33, st); check("t1_stall2", 32'(st), 32'(0));
    send(2'd2, 8'h44, st); check("t1_stall3", 32'(st), 32'(0));
    idle(5);

    // 2. Destination switch: 2 drain cycles + 1 switch cycle.
    send(2'd1, 8'hA1, st); check("t2_stall_a1", 32'(st), 32'(1));
    send(2'd3, 8'hB3, st); check("t2_stall_b3", 32'(st), 32'(3));
    idle(5);

    // 6. Bubble insertion on same destination.
    send(2'd3, 8'h61, st); check("t6_stall0", 32'(st), 32'(0));
    s_valid = 1'b0;
    @(negedge clk);
    check("t6_bubble_dm_in", 32'(dm_in), 32'(0));
    check("t6_state_stream", 32'(fsm_state), 32'(STREAM));
    @(posedge clk); #1;
    check("t6_state_drain", 32'(fsm_state), 32'(DRAIN));
    send(3'd3, 8'h63, st); check("t6_stall1", 32'(st), 32'(0));
    check("t6_state_stream2", 32'(fsm_state), 32'(STREAM));
    idle(5);

    // 3. Reset while two beats are in flight.
    send(2'd0, 8'h71, st); check("t3_stall0", 32'(st), 32'(1));
    send(2'd0, 8'h72, st); check("t3_stall1", 32'(st), 32'(0));
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h99;
    exp_q.delete();
    due_q.delete();
    @(negedge clk);
    check("t3_rst_m_valid", 32'(m_valid), 32'(0));
    check("t3_rst_busy", 32'(busy), 32'(0));
    check("t3_rst_s_ready", 32'(s_ready), 32'(0));
    @(posedge clk); #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t3_post_m_valid", 32'(m_valid), 32'(0));
      check("t3_post_busy", 32'(busy), 32'(0));
      check("t3_post_dm_sel", 32'(dm_sel), 32'(0));
    end
    @(posedge clk); #1;
    send(2'd0, 8'h73, st); check("t3_resume_stall", 32'(st), 32'(0));
    idle(5);

    // Random traffic through the scoreboard.
    for (int i = 0; i < 16; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), st);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(8);
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("final_busy", 32'(busy), 32'(0));

    // 4. Out-of-range destination (OUTPUT_COUNT=3).
    v3 = 1'b1; d3 = 2'd3; x3 = 8'hEE;
    @(negedge clk);
    check("t4_bad_ready", 32'(r3), 32'(1));
    check("t4_bad_dm_in", 32'(in3), 32'(0));
    @(posedge clk); #1;
    d3 = 2'd0; x3 = 8'h5A;
    @(negedge clk);
    check("t4_good_ready", 32'(r3), 32'(1));
    check("t4_good_dm_in", 32'(in3), 32'(8'h5A));
    check("t4_sel_kept", 32'(sel3), 32'(0));
    @(posedge clk); #1;
    v3 = 1'b0;
    @(negedge clk);
    check("t4_dropped_m_valid", 32'(mv3), 32'(0));
    @(negedge clk);
    check("t4_good_m_valid", 32'(mv3), 32'(3'b001));
    @(negedge clk);
    check("t4_busy_done", 32'(busy3), 32'(0));
    @(posedge clk); #1;

    // 5. LATENCY=0: alternating destinations, no stall, same-cycle valid.
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1; d0 = 2'(i % 2); x0 = 8'(8'h30 + i);
      @(negedge clk);
      check("t5_ready", 32'(r0), 32'(1));
      check("t5_m_valid", 32'(mv0), 32'(4'b0001 << (i % 2)));
      check("t5_dm_sel", 32'(sel0), 32'(i % 2));
      check("t5_dm_in", 32'(in0), 32'(8'h30 + i));
      @(posedge clk); #1;
    end
    v0 = 1'b0;
    @(negedge clk);
    check("t5_idle_m_valid", 32'(mv0), 32'(0));
    check("t5_idle_busy", 32'(busy0), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
